// File: rtl/seq_det_sched_if.sv
// Handshake bundle for seq_det_sched.
//  req_valid/req_data/req_ready : word sources, one lane per requester,
//                                 word i at req_data[i*WIDTH +: WIDTH]
//  res_valid/res_ready/res_cnt/res_id : result port (valid/ready)
// master = requesters + result consumer, slave = scheduler.
interface seq_det_sched_if #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 10,
  parameter int CNT_W = 4,
  parameter int ID_W  = 1
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   res_valid;
  logic                   res_ready;
  logic [CNT_W-1:0]       res_cnt;
  logic [ID_W-1:0]        res_id;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_cnt, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_cnt, res_id
  );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one external serial "11001" detector among
// N_REQ word sources. A granted word is shifted into the detector MSB-first
// after a one-cycle detector clear; z pulses are counted and returned with
// the requester id.
// Ports:
//  clk       : rising-edge clock
//  reset     : asynchronous, active-low
//  bus       : requester / result handshakes (slave side)
//  det_x     : serial bit to detector
//  det_reset : detector sync reset, active-high
//  det_z     : detector match flag (registered inside the detector)
//  busy      : high whenever not IDLE
module seq_det_sched #(
  parameter int N_REQ = 2,
  parameter int WIDTH = 10,
  parameter int CNT_W = 4,
  parameter int ID_W  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_det_sched_if.slave       bus,
  output logic                 det_x,
  output logic                 det_reset,
  input  logic                 det_z,
  output logic                 busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr;
  logic [ID_W-1:0]  rr_nxt;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic [WIDTH-1:0] gnt_word;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ID_W-1:0]  res_id_q;
  logic             res_valid_q;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    cand      = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr) + k) % N_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_idx   = cand;
        gnt_found = 1'b1;
      end
    end
  end

  assign rr_nxt   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign gnt_word = bus.req_data[gnt_idx*WIDTH +: WIDTH];

  // z observed on an edge belongs to the bit presented one cycle earlier.
  assign cnt_nxt  = (det_z && cnt != '1) ? cnt + CNT_W'(1) : cnt;

  assign bus.req_ready = (state == IDLE && gnt_found) ? (N_REQ'(1) << gnt_idx) : '0;
  assign bus.res_valid = res_valid_q;
  assign bus.res_cnt   = cnt;
  assign bus.res_id    = res_id_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr          <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      det_x       <= 1'b0;
      det_reset   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          det_reset <= 1'b1;
          det_x     <= 1'b0;
          if (gnt_found) begin
            shreg    <= gnt_word;
            res_id_q <= gnt_idx;
            cnt      <= '0;
            rr       <= rr_nxt;
            state    <= CLR;
          end
        end
        CLR: begin
          // det_reset is still high this cycle; line up bit 0 for SHIFT.
          det_reset <= 1'b0;
          det_x     <= shreg[WIDTH-1];
          shreg     <= shreg << 1;
          bit_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          cnt     <= cnt_nxt;
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == BW'(WIDTH - 1)) begin
            det_x <= 1'b0;
            state <= DRAIN;
          end else begin
            det_x <= shreg[WIDTH-1];
            shreg <= shreg << 1;
          end
        end
        DRAIN: begin
          // picks up the z produced by the final bit
          cnt         <= cnt_nxt;
          res_valid_q <= 1'b1;
          det_reset   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
